// File: rtl/shared_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_logic_unit_arbiter
// Description : One bitwise logic unit (AND/OR/XOR/ANDN) shared round-robin
//               between NUM_REQ joined lhs/rhs requesters. The result is held
//               in a one-slot output buffer and returned on the owner's channel.
//               Optional stall counter enabled by SHARED_LOGIC_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_logic_unit_arbiter #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_lhs,
  input  logic [NUM_REQ-1:0]             ins_lhs_valid,
  output logic [NUM_REQ-1:0]             ins_lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_rhs,
  input  logic [NUM_REQ-1:0]             ins_rhs_valid,
  output logic [NUM_REQ-1:0]             ins_rhs_ready,
  input  logic [NUM_REQ*2-1:0]           ins_op,
  output logic [NUM_REQ*DATA_TYPE-1:0]   outs,
  output logic [NUM_REQ-1:0]             outs_valid,
  input  logic [NUM_REQ-1:0]             outs_ready
`ifdef SHARED_LOGIC_ARB_STATS_EN
  ,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  logic                  r_full;
  logic [c_IDX_W-1:0]    r_owner;
  logic [c_IDX_W-1:0]    r_rr;
  logic [DATA_TYPE-1:0]  r_data;

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_grant_vec;
  logic [NUM_REQ-1:0]    w_outs_valid;
  logic                  w_drain;
  logic                  w_can_accept;
  logic                  w_found_hi;
  logic                  w_found_lo;
  logic                  w_found;
  logic                  w_fire;
  logic [c_IDX_W-1:0]    w_gnt_hi;
  logic [c_IDX_W-1:0]    w_gnt_lo;
  logic [c_IDX_W-1:0]    w_gnt;
  logic [c_IDX_W-1:0]    w_rr_next;
  logic [DATA_TYPE-1:0]  w_lhs;
  logic [DATA_TYPE-1:0]  w_rhs;
  logic [DATA_TYPE-1:0]  w_result;
  logic [1:0]            w_op;

  // A requester only competes once both operands are present (join).
  assign w_elig       = ins_lhs_valid & ins_rhs_valid;
  // The buffer's owner sees valid exactly when r_full is set outside reset.
  assign w_drain      = r_full & outs_ready[r_owner];
  assign w_can_accept = rst & (~r_full | w_drain);

  // Round-robin search: first eligible index at or above r_rr, else first below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_gnt_hi   = '0;
    w_found_lo = 1'b0;
    w_gnt_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_elig[i]) begin
        if (c_IDX_W'(i) >= r_rr) begin
          if (!w_found_hi) begin
            w_found_hi = 1'b1;
            w_gnt_hi   = c_IDX_W'(i);
          end
        end else if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_gnt_lo   = c_IDX_W'(i);
        end
      end
    end
  end

  assign w_found   = w_found_hi | w_found_lo;
  assign w_gnt     = w_found_hi ? w_gnt_hi : w_gnt_lo;
  assign w_fire    = w_can_accept & w_found;
  assign w_rr_next = (w_gnt == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + c_IDX_W'(1);

  // Steer the granted requester's operands and op code into the shared unit.
  always_comb begin
    w_lhs = '0;
    w_rhs = '0;
    w_op  = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == c_IDX_W'(i)) begin
        w_lhs = ins_lhs[i*DATA_TYPE +: DATA_TYPE];
        w_rhs = ins_rhs[i*DATA_TYPE +: DATA_TYPE];
        w_op  = ins_op[i*2 +: 2];
      end
    end
  end

  // The shared bitwise logic unit; every op code is defined.
  always_comb begin
    case (w_op)
      2'b00:   w_result = w_lhs & w_rhs;
      2'b01:   w_result = w_lhs | w_rhs;
      2'b10:   w_result = w_lhs ^ w_rhs;
      default: w_result = w_lhs & ~w_rhs;
    endcase
  end

  // One-hot readies for the winner and one-hot valid for the buffer owner.
  always_comb begin
    w_grant_vec  = '0;
    w_outs_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant_vec[i]  = w_fire & (w_gnt == c_IDX_W'(i));
      w_outs_valid[i] = rst & r_full & (r_owner == c_IDX_W'(i));
    end
  end

  assign ins_lhs_ready = w_grant_vec;
  assign ins_rhs_ready = w_grant_vec;
  assign outs_valid    = w_outs_valid;
  assign outs          = {NUM_REQ{r_data}};

  // Output buffer and round-robin pointer; a grant may refill a draining slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full  <= 1'b0;
      r_owner <= '0;
      r_data  <= '0;
      r_rr    <= '0;
    end else if (w_fire) begin
      r_full  <= 1'b1;
      r_owner <= w_gnt;
      r_data  <= w_result;
      r_rr    <= w_rr_next;
    end else if (w_drain) begin
      r_full  <= 1'b0;
    end
  end

`ifdef SHARED_LOGIC_ARB_STATS_EN
  logic [31:0] r_stall;

  // Saturating count of cycles the owner back-pressures a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (r_full && !outs_ready[r_owner] && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: doc/shared_logic_unit_arbiter.md
Name: shared_logic_unit_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/ANDN) between NUM_REQ dataflow requesters.
- Each requester presents an lhs/rhs operand pair with valid/ready handshakes and an op code.
- A round-robin arbiter grants one joined pair per cycle; the result is registered in a one-slot output buffer and returned on the owner's output channel.
- Sits wherever multiple low-utilisation logic ops are folded onto a single unit.

Parameters:
- DATA_TYPE, 32, operand/result width in bits.
- NUM_REQ, 2, number of requesters, legal range 2..8.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-low (state cleared on a rising clk edge while rst=0).
- ins_lhs  in  NUM_REQ*DATA_TYPE  lhs operands; requester i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_lhs_valid  in  NUM_REQ  per-requester lhs valid.
- ins_lhs_ready  out  NUM_REQ  per-requester lhs ready.
- ins_rhs  in  NUM_REQ*DATA_TYPE  rhs operands, same packing as ins_lhs.
- ins_rhs_valid  in  NUM_REQ  per-requester rhs valid.
- ins_rhs_ready  out  NUM_REQ  per-requester rhs ready.
- ins_op  in  NUM_REQ*2  op per requester: 00 AND, 01 OR, 10 XOR, 11 lhs AND NOT rhs; sampled with the operands.
- outs  out  NUM_REQ*DATA_TYPE  results, same packing.
- outs_valid  out  NUM_REQ  per-requester result valid.
- outs_ready  in  NUM_REQ  per-requester result ready.

Behaviour:
- Requester i is eligible when ins_lhs_valid[i] and ins_rhs_valid[i] are both 1 (join).
- State:
  - buf_full (1 bit).
  - buf_owner (index).
  - buf_data (DATA_TYPE).
  - rr_ptr (index of highest priority).
- can_accept = !buf_full OR (outs_ready[buf_owner] AND outs_valid[buf_owner]), i.e. the buffer is empty or draining this cycle.
- Grant: when can_accept=1, pick the first eligible requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - ins_lhs_ready[g] = ins_rhs_ready[g] = 1, all other readies 0.
  - No eligible requester: no grant, all readies 0.
- Readies never assert for a non-eligible requester. A lone lhs_valid or rhs_valid is never consumed, so there are no partial joins.
- On grant (fire):
  - buf_data <= op(lhs[g], rhs[g]).
  - buf_owner <= g.
  - buf_full <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Without a grant, rr_ptr holds.
- Drain without grant: buf_full <= 0.
- Drain and grant in the same cycle are both legal; full throughput is 1 result/cycle.
- Latency: operands accepted at edge N appear on outs[owner] with outs_valid[owner]=1 immediately after edge N (one register stage).
- outs_valid[i] = buf_full AND (buf_owner==i).
- Every outs slice is driven with buf_data. Consumers must qualify with valid.
- Backpressure: while buf_full and the owner's outs_ready=0:
  - buf_data, buf_owner and outs_valid are held stable.
  - All ins readies are 0.
  - rr_ptr is unchanged.
- Fairness: with all requesters continuously eligible and outputs always ready, grant order is 0,1,...,NUM_REQ-1,0,... Any requester waits at most NUM_REQ-1 grants.
- Reset (rst=0 at an edge), including mid-transfer:
  - buf_full=0, buf_owner=0, buf_data=0, rr_ptr=0.
  - Any held result is dropped.
  - While rst=0, all ins readies and outs_valid are forced to 0.
- ins_op values are pure decode; all four codes are defined, with no illegal values.
- No combinational path from outs_ready to outs_valid. outs_ready[buf_owner] reaches the ins readies combinationally, which is intended for pipelining.

Optional Feature:
- Macro SHARED_LOGIC_ARB_STATS_EN.
- When defined, adds output port stall_cycles (out, 32): a saturating counter.
  - Increments each cycle that buf_full=1 and outs_ready[buf_owner]=0.
  - Holds at 32'hFFFFFFFF.
  - Cleared by reset.
- When not defined, the port and counter are absent and the behaviour is otherwise identical.

Test Plan:
- Single op: NUM_REQ=2, req0 lhs=32'hF0F0_00FF, rhs=32'h0FF0_0F0F, op=00, outs_ready=2'b11 -> ins readies[0] high one cycle; next cycle outs_valid=2'b01, outs[0]=32'h00F0_000F.
- Op coverage on req1 (lhs=32'hAAAA_5555, rhs=32'hFFFF_0000):
  - op=01 -> 32'hFFFF_5555.
  - op=10 -> 32'h5555_5555.
  - op=11 -> 32'h0000_5555.
- Round robin: both requesters continuously eligible, outputs always ready, 6 cycles -> grants 0,1,0,1,0,1; outs_valid alternates 01,10,...; one result per cycle.
- Backpressure: req0 result held with outs_ready[0]=0 for 3 cycles while req1 is eligible:
  - outs[0] stable, all readies 0.
  - Release -> req1 granted in the same cycle as drain.
  - With SHARED_LOGIC_ARB_STATS_EN, stall_cycles=3.
- Partial join: req0 lhs_valid=1, rhs_valid=0 for 4 cycles -> ins_lhs_ready[0]=0 throughout; no outs_valid. Raising rhs_valid -> grant next evaluated cycle.
- Reset mid-operation: rst=0 for one edge while buf_full with outs_ready=0 -> outs_valid=0, readies 0 during reset. After release with both eligible -> req0 granted first (rr_ptr=0).
